// File: rtl/rom_sweep_pkg.sv
// Shared types, pattern modes, CRC constants and the expected-word generator for the ROM sweep checker.
package rom_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sweep_state_t;

  localparam logic [1:0] MODE_ONES  = 2'd0;
  localparam logic [1:0] MODE_ZEROS = 2'd1;
  localparam logic [1:0] MODE_ADDR  = 2'd2;
  localparam logic [1:0] MODE_NADDR = 2'd3;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  localparam int MAX_DATA_W = 1152;
  localparam int MAX_ADDR_W = 32;

  // Address replicated LSB-first across the word; the caller truncates to its data width.
  function automatic logic [MAX_DATA_W-1:0] exp_word(input logic [1:0]            mode,
                                                     input logic [MAX_ADDR_W-1:0] addr,
                                                     input int                    addr_w);
    logic [MAX_DATA_W-1:0] rep;
    rep = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      rep[i] = addr[i % addr_w];
    end
    case (mode)
      MODE_ONES:  exp_word = '1;
      MODE_ZEROS: exp_word = '0;
      MODE_ADDR:  exp_word = rep;
      default:    exp_word = ~rep;
    endcase
  endfunction

  // MSB-first, non-reflected CRC-32 over one 32-bit folded word.
  function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/rom_sweep_lat_pipe.sv
// {vld, addr} delay line matching the ROM read latency; flush drops all in-flight entries.
module rom_sweep_lat_pipe #(
  parameter int DEPTH      = 1,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic                  flush,
  input  logic                  in_vld,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_vld,
  output logic [ADDR_WIDTH-1:0] out_addr
);

  logic [DEPTH-1:0]      vld_q;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else begin
      vld_q[0]  <= in_vld;
      addr_q[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_addr = addr_q[DEPTH-1];

endmodule

// File: rtl/rom_sweep_checker.sv
// Self-checking ROM sweep sequencer: reads every address once, compares against a pattern, reports errors.
// Optional ROM_SWEEP_SIGNATURE_EN adds a CRC-32 signature output sig over the aligned read data.
//
// state | meaning
// IDLE  | waiting for start; results held
// SWEEP | one read per cycle, addresses 0 .. 2**ADDR_WIDTH-1
// DRAIN | waiting RD_LATENCY cycles for the last read to reach the compare
// DONE  | last compare landed; done pulse, pass valid
module rom_sweep_checker
  import rom_sweep_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 144,
  parameter int RD_LATENCY    = 1,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     tb_rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               mode,
  output logic [ADDR_WIDTH-1:0]    rom_addr,
  output logic                     rom_rd_en,
  input  logic [DATA_WIDTH-1:0]    rom_rd_data,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic [ADDR_WIDTH-1:0]    first_err_addr,
  output logic                     first_err_vld
`ifdef ROM_SWEEP_SIGNATURE_EN
  ,
  output logic [31:0]              sig
`endif
);

  localparam int DCW = $clog2(RD_LATENCY + 1);
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(RD_LATENCY - 1);

  sweep_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DCW-1:0]        drain_cnt;
  logic [1:0]            mode_q;
  logic                  sweep_start;
  logic                  aborting;
  logic                  last_addr;
  logic                  tail_vld;
  logic [ADDR_WIDTH-1:0] tail_addr;
  logic                  cmp_en;
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  mismatch;
  logic                  enter_done;

  assign last_addr = &addr_q;
  assign aborting  = abort && ((state_q == SWEEP) || (state_q == DRAIN));

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    sweep_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SWEEP;
          sweep_start = 1'b1;
        end
      end
      SWEEP: begin
        if (abort)          state_d = IDLE;
        else if (last_addr) state_d = DRAIN;
      end
      DRAIN: begin
        if (abort)                 state_d = IDLE;
        else if (drain_cnt == '0)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_done = (state_q == DRAIN) && (state_d == DONE);
  assign rom_rd_en  = (state_q == SWEEP);
  assign rom_addr   = addr_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      addr_q    <= '0;
      drain_cnt <= '0;
      mode_q    <= MODE_ONES;
    end else begin
      if (sweep_start) begin
        addr_q <= '0;
        mode_q <= mode;
      end else if ((state_q == SWEEP) && !last_addr) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
      end
      // Drain timer counts down to the cycle in which the last read reaches the pipe tail.
      if (state_q == SWEEP)                        drain_cnt <= DRAIN_LOAD;
      else if ((state_q == DRAIN) && (drain_cnt != '0)) drain_cnt <= drain_cnt - DCW'(1);
    end
  end

  rom_sweep_lat_pipe #(
    .DEPTH      (RD_LATENCY),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_lat_pipe (
    .clk      (clk),
    .tb_rst   (tb_rst),
    .flush    (aborting),
    .in_vld   (rom_rd_en),
    .in_addr  (addr_q),
    .out_vld  (tail_vld),
    .out_addr (tail_addr)
  );

  // An abort freezes the results, so the word arriving in the abort cycle is not counted.
  assign cmp_en = tail_vld && !aborting;

  always_comb begin
    exp_data = DATA_WIDTH'(exp_word(mode_q, MAX_ADDR_W'(tail_addr), ADDR_WIDTH));
    mismatch = cmp_en && (rom_rd_data != exp_data);
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_vld  <= 1'b0;
      pass           <= 1'b0;
    end else if (sweep_start) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_vld  <= 1'b0;
      pass           <= 1'b0;
    end else begin
      if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
        if (!first_err_vld) begin
          first_err_vld  <= 1'b1;
          first_err_addr <= tail_addr;
        end
      end
      // The final compare lands on the same edge, so fold it in directly.
      if (enter_done) pass <= (err_cnt == '0) && !mismatch;
    end
  end

`ifdef ROM_SWEEP_SIGNATURE_EN
  localparam int NSLICE = (DATA_WIDTH + 31) / 32;

  logic [NSLICE*32-1:0] data_pad;
  logic [31:0]          fold;

  always_comb begin
    data_pad                 = '0;
    data_pad[DATA_WIDTH-1:0] = rom_rd_data;
    fold                     = '0;
    for (int s = 0; s < NSLICE; s++) fold = fold ^ data_pad[s*32 +: 32];
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst)           sig <= '0;
    else if (sweep_start) sig <= CRC_INIT;
    else if (cmp_en)      sig <= crc32_word(sig, fold);
  end
`endif

endmodule

// File: tb/tb_rom_sweep_checker.sv
// Bench for rom_sweep_checker: two instances (latency 1 / 8-bit counter, latency 2 / 3-bit counter) share one ROM image.
module tb_rom_sweep_checker;

  localparam int AW = 4;
  localparam int DW = 144;
  localparam int NW = 16;

  logic clk = 1'b0;
  logic tb_rst;
  logic start, abort;
  logic [1:0] mode;

  logic [AW-1:0] addr_a, addr_b, fea_a, fea_b;
  logic          rd_en_a, rd_en_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b, fev_a, fev_b;
  logic [7:0]    err_a;
  logic [2:0]    err_b;
  logic [DW-1:0] q_a, q_b1, q_b2;
  logic [DW-1:0] rom_mem [NW];
`ifdef ROM_SWEEP_SIGNATURE_EN
  logic [31:0]   sig_a, sig_b;
`endif

  int errors = 0;
  int checks = 0;
  int busy_n_a, busy_n_b, rd_n_a, rd_n_b, done_n_a, done_n_b;

  always #5 clk = ~clk;

  rom_sweep_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .ERR_CNT_WIDTH(8)) u_a (
    .clk(clk), .tb_rst(tb_rst), .start(start), .abort(abort), .mode(mode),
    .rom_addr(addr_a), .rom_rd_en(rd_en_a), .rom_rd_data(q_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .first_err_addr(fea_a), .first_err_vld(fev_a)
`ifdef ROM_SWEEP_SIGNATURE_EN
    , .sig(sig_a)
`endif
  );

  rom_sweep_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .ERR_CNT_WIDTH(3)) u_b (
    .clk(clk), .tb_rst(tb_rst), .start(start), .abort(abort), .mode(mode),
    .rom_addr(addr_b), .rom_rd_en(rd_en_b), .rom_rd_data(q_b2),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .first_err_addr(fea_b), .first_err_vld(fev_b)
`ifdef ROM_SWEEP_SIGNATURE_EN
    , .sig(sig_b)
`endif
  );

  // Model ROMs: synchronous read, the second with an extra output register.
  always_ff @(posedge clk) begin
    if (rd_en_a) q_a  <= rom_mem[addr_a];
    if (rd_en_b) q_b1 <= rom_mem[addr_b];
    q_b2 <= q_b1;
  end

  typedef struct {
    int rom_kind;   // 0 all-ones, 1 address pattern
    int zero_word;  // word forced to zero, -1 for none
    int mode;
    int e8, e3, first, vld, pass_exp;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int m, input int a);
    logic [DW-1:0] w;
    w = '0;
    for (int r = 0; r < DW / AW; r++) w = (w << AW) | DW'(a);
    case (m)
      0:       return '1;
      1:       return '0;
      2:       return w;
      default: return ~w;
    endcase
  endfunction

  task automatic fill_rom(input int kind, input int zero_word);
    for (int a = 0; a < NW; a++) rom_mem[a] = (kind == 0) ? '1 : pat(2, a);
    if (zero_word >= 0) rom_mem[zero_word] = '0;
  endtask

  task automatic model(input int m, output int cnt, output int first);
    cnt = 0;
    first = 0;
    for (int a = 0; a < NW; a++) begin
      if (rom_mem[a] != pat(m, a)) begin
        if (cnt == 0) first = a;
        cnt++;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    while ((busy_a || busy_b) && cyc < 200) begin
      busy_n_a += int'(busy_a); busy_n_b += int'(busy_b);
      rd_n_a   += int'(rd_en_a); rd_n_b  += int'(rd_en_b);
      done_n_a += int'(done_a); done_n_b += int'(done_b);
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_timeout"}, 64'(cyc < 200), 64'(1));
  endtask

  // Mode is scrambled after start to confirm the DUT latched it.
  task automatic run_sweep(input int m, input string tag);
    busy_n_a = 0; busy_n_b = 0; rd_n_a = 0; rd_n_b = 0; done_n_a = 0; done_n_b = 0;
    @(negedge clk);
    mode  = 2'(m);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode  = ~2'(m);
    wait_idle(tag);
  endtask

  task automatic check_results(input string tag, input int e8, input int e3, input int first,
                               input int vld, input int pexp);
    chk({tag, "_busy_len_a"}, 64'(busy_n_a), 64'(NW + 2));
    chk({tag, "_busy_len_b"}, 64'(busy_n_b), 64'(NW + 3));
    chk({tag, "_rd_en_a"}, 64'(rd_n_a), 64'(NW));
    chk({tag, "_rd_en_b"}, 64'(rd_n_b), 64'(NW));
    chk({tag, "_done_a"}, 64'(done_n_a), 64'(1));
    chk({tag, "_done_b"}, 64'(done_n_b), 64'(1));
    chk({tag, "_err_a"}, 64'(err_a), 64'(e8));
    chk({tag, "_err_b"}, 64'(err_b), 64'(e3));
    chk({tag, "_fev_a"}, 64'(fev_a), 64'(vld));
    chk({tag, "_fev_b"}, 64'(fev_b), 64'(vld));
    if (vld != 0) begin
      chk({tag, "_fea_a"}, 64'(fea_a), 64'(first));
      chk({tag, "_fea_b"}, 64'(fea_b), 64'(first));
    end
    chk({tag, "_pass_a"}, 64'(pass_a), 64'(pexp));
    chk({tag, "_pass_b"}, 64'(pass_b), 64'(pexp));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 64'({busy_a, busy_b}), 64'(0));
    chk({tag, "_done"}, 64'({done_a, done_b}), 64'(0));
    chk({tag, "_pass"}, 64'({pass_a, pass_b}), 64'(0));
    chk({tag, "_err"}, 64'({err_a, err_b}), 64'(0));
    chk({tag, "_fev"}, 64'({fev_a, fev_b}), 64'(0));
    chk({tag, "_fea"}, 64'({fea_a, fea_b}), 64'(0));
    chk({tag, "_addr"}, 64'({addr_a, addr_b}), 64'(0));
    chk({tag, "_rd_en"}, 64'({rd_en_a, rd_en_b}), 64'(0));
  endtask

`ifdef ROM_SWEEP_SIGNATURE_EN
  function automatic logic [31:0] sig_model();
    logic [31:0] crc, f;
    logic [191:0] pad;
    crc = 32'hFFFFFFFF;
    for (int a = 0; a < NW; a++) begin
      pad = 192'(rom_mem[a]);
      f = '0;
      for (int s = 0; s < 6; s++) f ^= pad[s*32 +: 32];
      for (int b = 31; b >= 0; b--) begin
        if (crc[31] ^ f[b]) crc = (crc << 1) ^ 32'h04C11DB7;
        else                crc = crc << 1;
      end
    end
    return crc;
  endfunction
`endif

  initial begin
    int cnt, first, m, bit_idx;
    logic [DW-1:0] w;

    tb_rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0;
    fill_rom(0, -1);
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    tb_rst = 1'b0;

    tbl[0] = '{0, -1, 0,  0, 0, 0, 0, 1};
    tbl[1] = '{0,  5, 0,  1, 1, 5, 1, 0};
    tbl[2] = '{0, -1, 1, 16, 7, 0, 1, 0};
    tbl[3] = '{1, -1, 2,  0, 0, 0, 0, 1};
    tbl[4] = '{1, -1, 3, 16, 7, 0, 1, 0};
    tbl[5] = '{1, -1, 0, 15, 7, 0, 1, 0};
    tbl[6] = '{1, -1, 1, 15, 7, 1, 1, 0};
    for (int i = 0; i < 7; i++) begin
      fill_rom(tbl[i].rom_kind, tbl[i].zero_word);
      run_sweep(tbl[i].mode, $sformatf("tbl%0d", i));
      check_results($sformatf("tbl%0d", i), tbl[i].e8, tbl[i].e3, tbl[i].first, tbl[i].vld,
                    tbl[i].pass_exp);
    end

    // Abort at the 8th SWEEP cycle with a simultaneous start that must be ignored.
    fill_rom(0, -1);
    @(negedge clk);
    mode = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort_busy", 64'({busy_a, busy_b}), 64'(0));
    chk("abort_rd_en", 64'({rd_en_a, rd_en_b}), 64'(0));
    done_n_a = 0; busy_n_a = 0;
    for (int c = 0; c < 25; c++) begin
      done_n_a += int'(done_a) + int'(done_b);
      busy_n_a += int'(busy_a) + int'(busy_b);
      @(negedge clk);
    end
    chk("abort_no_done", 64'(done_n_a), 64'(0));
    chk("abort_stays_idle", 64'(busy_n_a), 64'(0));
    chk("abort_pass", 64'({pass_a, pass_b}), 64'(0));

    // start and abort together while idle: start wins.
    start = 1'b1; abort = 1'b1; mode = 2'd0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_wins_busy", 64'({busy_a, busy_b}), 64'(3));
    wait_idle("start_wins");
    chk("start_wins_pass", 64'({pass_a, pass_b}), 64'(3));

    // Reset in the middle of an error-accumulating sweep.
    @(negedge clk);
    mode = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    tb_rst = 1'b1;
    #1;
    check_zero("midreset");
    @(negedge clk);
    tb_rst = 1'b0;
    @(negedge clk);
    chk("midreset_idle", 64'({busy_a, busy_b, done_a, done_b}), 64'(0));

    // Randomized sweeps: pattern ROM with scattered single-bit corruptions.
    for (int it = 0; it < 10; it++) begin
      m = int'($urandom_range(0, 3));
      for (int a = 0; a < NW; a++) begin
        w = pat(int'($urandom_range(0, 3)) == 0 ? int'($urandom_range(0, 3)) : m, a);
        if ($urandom_range(0, 3) == 0) begin
          bit_idx = int'($urandom_range(0, DW - 1));
          w[bit_idx] = ~w[bit_idx];
        end
        rom_mem[a] = w;
      end
      model(m, cnt, first);
      run_sweep(m, $sformatf("rnd%0d", it));
      check_results($sformatf("rnd%0d", it), (cnt > 255) ? 255 : cnt, (cnt > 7) ? 7 : cnt,
                    first, (cnt > 0) ? 1 : 0, (cnt == 0) ? 1 : 0);
    end

`ifdef ROM_SWEEP_SIGNATURE_EN
    fill_rom(0, -1);
    for (int r = 0; r < 2; r++) begin
      run_sweep(0, $sformatf("sig%0d", r));
      chk($sformatf("sig%0d_a", r), 64'(sig_a), 64'(sig_model()));
      chk($sformatf("sig%0d_b", r), 64'(sig_b), 64'(sig_model()));
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
